// File: rtl/hack_kbd_pkg.sv
// Shared constants and types for the Hack keyboard front end.
// Optional caps-lock support is selected with the HACK_KBD_CAPSLOCK_EN macro.
package hack_kbd_pkg;

    // Hack special-key codes
    localparam logic [7:0] KEY_NEWLINE   = 8'd128;
    localparam logic [7:0] KEY_BACKSPACE = 8'd129;
    localparam logic [7:0] KEY_LEFT      = 8'd130;
    localparam logic [7:0] KEY_UP        = 8'd131;
    localparam logic [7:0] KEY_RIGHT     = 8'd132;
    localparam logic [7:0] KEY_DOWN      = 8'd133;
    localparam logic [7:0] KEY_HOME      = 8'd134;
    localparam logic [7:0] KEY_END       = 8'd135;
    localparam logic [7:0] KEY_PGUP      = 8'd136;
    localparam logic [7:0] KEY_PGDN      = 8'd137;
    localparam logic [7:0] KEY_INSERT    = 8'd138;
    localparam logic [7:0] KEY_DELETE    = 8'd139;
    localparam logic [7:0] KEY_ESC       = 8'd140;
    localparam logic [7:0] KEY_F1        = 8'd141;
    localparam logic [7:0] KEY_F2        = 8'd142;
    localparam logic [7:0] KEY_F3        = 8'd143;
    localparam logic [7:0] KEY_F4        = 8'd144;
    localparam logic [7:0] KEY_F5        = 8'd145;
    localparam logic [7:0] KEY_F6        = 8'd146;
    localparam logic [7:0] KEY_F7        = 8'd147;
    localparam logic [7:0] KEY_F8        = 8'd148;
    localparam logic [7:0] KEY_F9        = 8'd149;
    localparam logic [7:0] KEY_F10       = 8'd150;
    localparam logic [7:0] KEY_F11       = 8'd151;
    localparam logic [7:0] KEY_F12       = 8'd152;

    // PS/2 set-2 modifier codes
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;
    localparam logic [7:0] PS2_CTRL   = 8'h14;
    localparam logic [7:0] PS2_ALT    = 8'h11;
    localparam logic [7:0] PS2_CAPS   = 8'h58;

    // Identity of the key currently driving the output
    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } held_key_t;

endpackage

// File: rtl/hack_keymap.sv
// Combinational PS/2 set-2 to Hack key code translation; 0 means unmapped.
// Letters honour shift^caps, everything else honours shift only.
module hack_keymap
    import hack_kbd_pkg::*;
(
    input  logic       ext_i,
    input  logic [7:0] code_i,
    input  logic       shift_i,
    input  logic       caps_i,
    output logic [7:0] hack_code_o
);

    logic [7:0] base;
    logic [7:0] shifted;
    logic       letter;

    // Look up unshifted/shifted pair, then pick by the effective shift
    always_comb begin
        base    = 8'h00;
        shifted = 8'h00;
        if (ext_i) begin
            case (code_i)
                8'h6B: base = KEY_LEFT;
                8'h75: base = KEY_UP;
                8'h74: base = KEY_RIGHT;
                8'h72: base = KEY_DOWN;
                8'h6C: base = KEY_HOME;
                8'h69: base = KEY_END;
                8'h7D: base = KEY_PGUP;
                8'h7A: base = KEY_PGDN;
                8'h70: base = KEY_INSERT;
                8'h71: base = KEY_DELETE;
                default: ;
            endcase
        end else begin
            case (code_i)
                // letters: shifted form derived below
                8'h1C: base = 8'h61;
                8'h32: base = 8'h62;
                8'h21: base = 8'h63;
                8'h23: base = 8'h64;
                8'h24: base = 8'h65;
                8'h2B: base = 8'h66;
                8'h34: base = 8'h67;
                8'h33: base = 8'h68;
                8'h43: base = 8'h69;
                8'h3B: base = 8'h6A;
                8'h42: base = 8'h6B;
                8'h4B: base = 8'h6C;
                8'h3A: base = 8'h6D;
                8'h31: base = 8'h6E;
                8'h44: base = 8'h6F;
                8'h4D: base = 8'h70;
                8'h15: base = 8'h71;
                8'h2D: base = 8'h72;
                8'h1B: base = 8'h73;
                8'h2C: base = 8'h74;
                8'h3C: base = 8'h75;
                8'h2A: base = 8'h76;
                8'h1D: base = 8'h77;
                8'h22: base = 8'h78;
                8'h35: base = 8'h79;
                8'h1A: base = 8'h7A;
                // digits, US layout shifted symbols
                8'h16: begin base = 8'h31; shifted = 8'h21; end
                8'h1E: begin base = 8'h32; shifted = 8'h40; end
                8'h26: begin base = 8'h33; shifted = 8'h23; end
                8'h25: begin base = 8'h34; shifted = 8'h24; end
                8'h2E: begin base = 8'h35; shifted = 8'h25; end
                8'h36: begin base = 8'h36; shifted = 8'h5E; end
                8'h3D: begin base = 8'h37; shifted = 8'h26; end
                8'h3E: begin base = 8'h38; shifted = 8'h2A; end
                8'h46: begin base = 8'h39; shifted = 8'h28; end
                8'h45: begin base = 8'h30; shifted = 8'h29; end
                // punctuation
                8'h0E: begin base = 8'h60; shifted = 8'h7E; end
                8'h4E: begin base = 8'h2D; shifted = 8'h5F; end
                8'h55: begin base = 8'h3D; shifted = 8'h2B; end
                8'h54: begin base = 8'h5B; shifted = 8'h7B; end
                8'h5B: begin base = 8'h5D; shifted = 8'h7D; end
                8'h5D: begin base = 8'h5C; shifted = 8'h7C; end
                8'h4C: begin base = 8'h3B; shifted = 8'h3A; end
                8'h52: begin base = 8'h27; shifted = 8'h22; end
                8'h41: begin base = 8'h2C; shifted = 8'h3C; end
                8'h49: begin base = 8'h2E; shifted = 8'h3E; end
                8'h4A: begin base = 8'h2F; shifted = 8'h3F; end
                // shift-insensitive keys
                8'h29: base = 8'h20;
                8'h5A: base = KEY_NEWLINE;
                8'h66: base = KEY_BACKSPACE;
                8'h76: base = KEY_ESC;
                8'h05: base = KEY_F1;
                8'h06: base = KEY_F2;
                8'h04: base = KEY_F3;
                8'h0C: base = KEY_F4;
                8'h03: base = KEY_F5;
                8'h0B: base = KEY_F6;
                8'h83: base = KEY_F7;
                8'h0A: base = KEY_F8;
                8'h01: base = KEY_F9;
                8'h09: base = KEY_F10;
                8'h78: base = KEY_F11;
                8'h07: base = KEY_F12;
                default: ;
            endcase
        end

        letter = (base >= 8'h61) && (base <= 8'h7A);
        if (letter) begin
            shifted = base ^ 8'h20;
        end else if (shifted == 8'h00) begin
            shifted = base;
        end
    end

    // Caps only affects letters
    always_comb begin
        hack_code_o = ((letter ? (shift_i ^ caps_i) : shift_i) ? shifted : base);
    end

endmodule

// File: rtl/hack_keyboard.sv
// MiSTer ps2_key event stream to Hack keyboard register code.
// Define HACK_KBD_CAPSLOCK_EN to build the caps-lock toggle on code 0x58.
module hack_keyboard
    import hack_kbd_pkg::*;
#(
    parameter int unsigned RELEASE_ANY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    output logic [7:0]  hack_scancode,
    output logic        key_event
);

    logic       tog_q;
    logic       ev;
    logic       make;
    held_key_t  cur;

    logic       shift_l_q, shift_l_d;
    logic       shift_r_q, shift_r_d;
    held_key_t  held_q, held_d;
    logic [7:0] scancode_q, scancode_d;
    logic       key_event_q;
    logic       caps;
    logic [7:0] map_code;

`ifdef HACK_KBD_CAPSLOCK_EN
    logic       caps_q, caps_d;
    assign caps = caps_q;
`else
    assign caps = 1'b0;
`endif

    // Decode the incoming event fields; a toggle edge marks a new event
    always_comb begin
        ev       = ps2_key[10] ^ tog_q;
        make     = ps2_key[9];
        cur.ext  = ps2_key[8];
        cur.code = ps2_key[7:0];
    end

    hack_keymap u_keymap (
        .ext_i       (cur.ext),
        .code_i      (cur.code),
        .shift_i     (shift_l_q | shift_r_q),
        .caps_i      (caps),
        .hack_code_o (map_code)
    );

    // Next-state for modifiers, held key and output code
    always_comb begin
        shift_l_d  = shift_l_q;
        shift_r_d  = shift_r_q;
        held_d     = held_q;
        scancode_d = scancode_q;
`ifdef HACK_KBD_CAPSLOCK_EN
        caps_d     = caps_q;
`endif
        if (ev) begin
            if (!cur.ext && cur.code == PS2_LSHIFT) begin
                shift_l_d = make;
            end else if (!cur.ext && cur.code == PS2_RSHIFT) begin
                shift_r_d = make;
            end else if (cur.code == PS2_CTRL || cur.code == PS2_ALT ||
                         cur.code == PS2_LSHIFT || cur.code == PS2_RSHIFT) begin
                // Right ctrl/alt and E0-prefixed fake shifts are swallowed too
            end
`ifdef HACK_KBD_CAPSLOCK_EN
            else if (!cur.ext && cur.code == PS2_CAPS) begin
                if (make) begin
                    caps_d = ~caps_q;
                end
            end
`endif
            else if (make) begin
                if (map_code != 8'h00) begin
                    scancode_d = map_code;
                    held_d     = cur;
                end
            end else if (cur == held_q || RELEASE_ANY != 0) begin
                scancode_d = 8'h00;
                held_d     = '0;
            end
        end
    end

    // State registers; synchronous active-low reset re-arms the toggle tracker
    always_ff @(posedge clk) begin
        tog_q <= ps2_key[10];
        if (!reset) begin
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
            held_q      <= '0;
            scancode_q  <= 8'h00;
            key_event_q <= 1'b0;
`ifdef HACK_KBD_CAPSLOCK_EN
            caps_q      <= 1'b0;
`endif
        end else begin
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            held_q      <= held_d;
            scancode_q  <= scancode_d;
            key_event_q <= (scancode_d != scancode_q);
`ifdef HACK_KBD_CAPSLOCK_EN
            caps_q      <= caps_d;
`endif
        end
    end

    // Registered outputs
    always_comb begin
        hack_scancode = scancode_q;
        key_event     = key_event_q;
    end

endmodule

// File: tb/tb_hack_keyboard.sv
// Directed bench for hack_keyboard: one instance per RELEASE_ANY setting, same stimulus.
module tb_hack_keyboard;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] ps2_key = '0;
    logic        tog = 1'b0;
    logic [7:0]  sc0, sc1;
    logic        ev0, ev1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    hack_keyboard #(.RELEASE_ANY(0)) dut0 (
        .clk           (clk),
        .reset         (reset),
        .ps2_key       (ps2_key),
        .hack_scancode (sc0),
        .key_event     (ev0)
    );

    hack_keyboard #(.RELEASE_ANY(1)) dut1 (
        .clk           (clk),
        .reset         (reset),
        .ps2_key       (ps2_key),
        .hack_scancode (sc1),
        .key_event     (ev1)
    );

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] e_sc0, input logic e_ev0,
                        input logic [7:0] e_sc1, input logic e_ev1);
        chk8({tag, " code ra0"}, sc0, e_sc0);
        chk1({tag, " event ra0"}, ev0, e_ev0);
        chk8({tag, " code ra1"}, sc1, e_sc1);
        chk1({tag, " event ra1"}, ev1, e_ev1);
    endtask

    // One PS/2 event, applied between edges and observed just after the next edge
    task automatic send(input logic mk, input logic ext, input logic [7:0] code);
        @(negedge clk);
        tog = ~tog;
        ps2_key = {tog, mk, ext, code};
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. reset with toggle activity, clean exit
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tog = ~tog;
            ps2_key = {tog, 1'b1, 1'b0, 8'h1C};
            @(posedge clk);
            #1;
            step("reset_hold", 8'h00, 1'b0, 8'h00, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        idle();
        step("reset_exit", 8'h00, 1'b0, 8'h00, 1'b0);
        idle();
        step("reset_exit2", 8'h00, 1'b0, 8'h00, 1'b0);

        // 2. basic make/break
        send(1'b1, 1'b0, 8'h1C); step("make_a", 8'h61, 1'b1, 8'h61, 1'b1);
        idle();                  step("hold_a", 8'h61, 1'b0, 8'h61, 1'b0);
        send(1'b0, 1'b0, 8'h1C); step("break_a", 8'h00, 1'b1, 8'h00, 1'b1);

        // 3. shift latched at make
        send(1'b1, 1'b0, 8'h12); step("make_lsh", 8'h00, 1'b0, 8'h00, 1'b0);
        send(1'b1, 1'b0, 8'h1C); step("make_A", 8'h41, 1'b1, 8'h41, 1'b1);
        send(1'b0, 1'b0, 8'h12); step("break_lsh", 8'h41, 1'b0, 8'h41, 1'b0);
        send(1'b0, 1'b0, 8'h1C); step("break_A", 8'h00, 1'b1, 8'h00, 1'b1);

        // 4. extended, keypad, special keys, remake
        send(1'b1, 1'b1, 8'h75); step("make_up", 8'h83, 1'b1, 8'h83, 1'b1);
        send(1'b0, 1'b1, 8'h75); step("break_up", 8'h00, 1'b1, 8'h00, 1'b1);
        send(1'b1, 1'b0, 8'h75); step("make_kp8", 8'h00, 1'b0, 8'h00, 1'b0);
        send(1'b1, 1'b0, 8'h5A); step("make_enter", 8'h80, 1'b1, 8'h80, 1'b1);
        send(1'b1, 1'b0, 8'h05); step("make_f1", 8'h8D, 1'b1, 8'h8D, 1'b1);
        send(1'b1, 1'b0, 8'h05); step("remake_f1", 8'h8D, 1'b0, 8'h8D, 1'b0);
        send(1'b0, 1'b0, 8'h05); step("break_f1", 8'h00, 1'b1, 8'h00, 1'b1);
        send(1'b0, 1'b0, 8'h5A); step("break_enter", 8'h00, 1'b0, 8'h00, 1'b0);
        send(1'b1, 1'b1, 8'h71); step("make_del", 8'h8B, 1'b1, 8'h8B, 1'b1);
        send(1'b0, 1'b1, 8'h71); step("break_del", 8'h00, 1'b1, 8'h00, 1'b1);
        send(1'b1, 1'b0, 8'h76); step("make_esc", 8'h8C, 1'b1, 8'h8C, 1'b1);
        send(1'b1, 1'b0, 8'h07); step("make_f12", 8'h98, 1'b1, 8'h98, 1'b1);
        send(1'b0, 1'b0, 8'h07); step("break_f12", 8'h00, 1'b1, 8'h00, 1'b1);
        send(1'b0, 1'b0, 8'h76); step("break_esc", 8'h00, 1'b0, 8'h00, 1'b0);
        send(1'b1, 1'b0, 8'h59); step("make_rsh", 8'h00, 1'b0, 8'h00, 1'b0);
        send(1'b1, 1'b0, 8'h16); step("make_bang", 8'h21, 1'b1, 8'h21, 1'b1);
        send(1'b0, 1'b0, 8'h59); step("break_rsh", 8'h21, 1'b0, 8'h21, 1'b0);
        send(1'b0, 1'b0, 8'h16); step("break_bang", 8'h00, 1'b1, 8'h00, 1'b1);
        send(1'b1, 1'b0, 8'h4A); step("make_slash", 8'h2F, 1'b1, 8'h2F, 1'b1);
        send(1'b1, 1'b0, 8'h29); step("make_space", 8'h20, 1'b1, 8'h20, 1'b1);
        send(1'b0, 1'b0, 8'h29); step("break_space", 8'h00, 1'b1, 8'h00, 1'b1);
        send(1'b0, 1'b0, 8'h4A); step("break_slash", 8'h00, 1'b0, 8'h00, 1'b0);
        send(1'b1, 1'b0, 8'h66); step("make_bksp", 8'h81, 1'b1, 8'h81, 1'b1);
        send(1'b0, 1'b0, 8'h66); step("break_bksp", 8'h00, 1'b1, 8'h00, 1'b1);

        // 5. overlapping keys, consumed modifiers, reset during hold
        send(1'b1, 1'b0, 8'h1C); step("ov_make_a", 8'h61, 1'b1, 8'h61, 1'b1);
        send(1'b1, 1'b0, 8'h32); step("ov_make_b", 8'h62, 1'b1, 8'h62, 1'b1);
        send(1'b1, 1'b0, 8'h14); step("ov_make_ctl", 8'h62, 1'b0, 8'h62, 1'b0);
        send(1'b0, 1'b0, 8'h14); step("ov_break_ctl", 8'h62, 1'b0, 8'h62, 1'b0);
        send(1'b0, 1'b0, 8'h1C); step("ov_break_a", 8'h62, 1'b0, 8'h00, 1'b1);
        send(1'b0, 1'b0, 8'h32); step("ov_break_b", 8'h00, 1'b1, 8'h00, 1'b0);
        send(1'b1, 1'b0, 8'h1C); step("pre_rst_a", 8'h61, 1'b1, 8'h61, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        idle();                  step("rst_hold", 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        idle();                  step("rst_release", 8'h00, 1'b0, 8'h00, 1'b0);
        send(1'b1, 1'b0, 8'h32); step("post_rst_b", 8'h62, 1'b1, 8'h62, 1'b1);
        send(1'b0, 1'b0, 8'h32); step("post_rst_brk", 8'h00, 1'b1, 8'h00, 1'b1);
        // an event coinciding with reset is lost, and no stale event follows
        @(negedge clk);
        reset = 1'b0;
        tog = ~tog;
        ps2_key = {tog, 1'b1, 1'b0, 8'h1C};
        idle();                  step("rst_wins", 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        idle();                  step("rst_wins_exit", 8'h00, 1'b0, 8'h00, 1'b0);

        // 6. caps lock
`ifdef HACK_KBD_CAPSLOCK_EN
        send(1'b1, 1'b0, 8'h58); step("caps_make", 8'h00, 1'b0, 8'h00, 1'b0);
        send(1'b0, 1'b0, 8'h58); step("caps_break", 8'h00, 1'b0, 8'h00, 1'b0);
        send(1'b1, 1'b0, 8'h1C); step("caps_A", 8'h41, 1'b1, 8'h41, 1'b1);
        send(1'b0, 1'b0, 8'h1C); step("caps_A_brk", 8'h00, 1'b1, 8'h00, 1'b1);
        send(1'b1, 1'b0, 8'h12); step("caps_lsh", 8'h00, 1'b0, 8'h00, 1'b0);
        send(1'b1, 1'b0, 8'h1C); step("caps_sh_a", 8'h61, 1'b1, 8'h61, 1'b1);
        send(1'b0, 1'b0, 8'h1C); step("caps_sh_brk", 8'h00, 1'b1, 8'h00, 1'b1);
        send(1'b0, 1'b0, 8'h12); step("caps_lsh_brk", 8'h00, 1'b0, 8'h00, 1'b0);
        send(1'b1, 1'b0, 8'h16); step("caps_one", 8'h31, 1'b1, 8'h31, 1'b1);
        send(1'b0, 1'b0, 8'h16); step("caps_one_brk", 8'h00, 1'b1, 8'h00, 1'b1);
`else
        send(1'b1, 1'b0, 8'h58); step("nocaps_make", 8'h00, 1'b0, 8'h00, 1'b0);
        send(1'b0, 1'b0, 8'h58); step("nocaps_break", 8'h00, 1'b0, 8'h00, 1'b0);
        send(1'b1, 1'b0, 8'h1C); step("nocaps_a", 8'h61, 1'b1, 8'h61, 1'b1);
        send(1'b0, 1'b0, 8'h1C); step("nocaps_a_brk", 8'h00, 1'b1, 8'h00, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
